// File: rtl/mult_alu_seq.sv
// mult_alu_seq: shift-and-add MULT/MULTU sequencer using the shared ALU; ports clk/rst, start/is_signed/op_a/op_b in, busy/done/hi/lo out, alu_first/alu_second/alu_op to ALU, alu_result/alu_zero from ALU
module mult_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_first,
  output logic [WIDTH-1:0] alu_second,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DEC_HI, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, hi_acc_q, hi_acc_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] count_q, count_d;
  logic is_signed_q, is_signed_d, neg_res_q, neg_res_d, lo_was_zero_q, lo_was_zero_d;
  logic busy_q, busy_d, done_q, done_d, carry;
  always_comb begin
    alu_first  = '0;
    alu_second = '0;
    alu_op     = OP_ADD;
    case (state_q)
      NEG_A:  begin alu_second = mcand_q; alu_op = OP_SUB; end
      NEG_B:  begin alu_second = mplier_q; alu_op = OP_SUB; end
      ITER:   begin alu_first = hi_acc_q; alu_second = mplier_q[0] ? mcand_q : '0; end
      NEG_LO: begin alu_second = mplier_q; alu_op = OP_SUB; end
      NEG_HI: begin alu_second = hi_acc_q; alu_op = OP_SUB; end
      DEC_HI: begin alu_first = hi_acc_q; alu_second = WIDTH'(1); alu_op = OP_SUB; end
      default: ;
    endcase
  end
  // ALU has no carry out; recover it from the operand and result sign bits
  assign carry = (alu_first[WIDTH-1] & alu_second[WIDTH-1]) |
                 ((alu_first[WIDTH-1] | alu_second[WIDTH-1]) & ~alu_result[WIDTH-1]);
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    hi_acc_d      = hi_acc_q;
    count_d       = count_q;
    is_signed_d   = is_signed_q;
    neg_res_d     = neg_res_q;
    lo_was_zero_d = lo_was_zero_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d     = op_a;
        mplier_d    = op_b;
        is_signed_d = is_signed;
        neg_res_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        hi_acc_d    = '0;
        count_d     = '0;
        state_d     = (is_signed & op_a[WIDTH-1]) ? NEG_A : (is_signed & op_b[WIDTH-1]) ? NEG_B : ITER;
      end
      NEG_A: begin
        mcand_d = alu_result;
        state_d = (is_signed_q & mplier_q[WIDTH-1]) ? NEG_B : ITER;
      end
      NEG_B: begin
        mplier_d = alu_result;
        state_d  = ITER;
      end
      ITER: begin
        // shift {carry, sum, mplier} right by one; product low bits fill mplier from the top
        {hi_acc_d, mplier_d} = {carry, alu_result, mplier_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        state_d = (count_q == CW'(WIDTH - 1)) ? (neg_res_q ? NEG_LO : DONE) : ITER;
      end
      NEG_LO: begin
        mplier_d      = alu_result;
        lo_was_zero_d = alu_zero;
        state_d       = NEG_HI;
      end
      NEG_HI: begin
        hi_acc_d = alu_result;
        state_d  = lo_was_zero_q ? DONE : DEC_HI;
      end
      DEC_HI: begin
        hi_acc_d = alu_result;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs load on entry to DONE so hi/lo are valid in the same cycle as the done pulse
  always_comb begin
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
    hi_d   = done_d ? hi_acc_d : hi_q;
    lo_d   = done_d ? mplier_d : lo_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      hi_acc_q      <= '0;
      count_q       <= '0;
      is_signed_q   <= 1'b0;
      neg_res_q     <= 1'b0;
      lo_was_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      hi_acc_q      <= hi_acc_d;
      count_q       <= count_d;
      is_signed_q   <= is_signed_d;
      neg_res_q     <= neg_res_d;
      lo_was_zero_q <= lo_was_zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_alu_seq.sv
// tb_mult_alu_seq: scoreboard bench for mult_alu_seq with a behavioural combinational ALU
module tb_mult_alu_seq;
  logic clk = 1'b0, rst, start, is_signed, busy, done, alu_zero;
  logic [31:0] op_a, op_b, hi, lo, alu_first, alu_second, alu_result;
  logic [2:0] alu_op;
  int checks = 0, failures = 0;
  typedef struct {logic [63:0] p; int lat;} exp_t;
  exp_t sb[$];
  mult_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_first(alu_first), .alu_second(alu_second),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );
  always #5 clk = ~clk;
  assign alu_result = (alu_op == 3'b110) ? alu_first - alu_second : alu_first + alu_second;
  assign alu_zero   = alu_result == 32'd0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input bit inj);
    exp_t e;
    int cyc = 1, bc = 0, extra = 0;
    logic [63:0] p;
    bit neg;
    p = s ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'd0, a} * {32'd0, b};
    neg = s & (a[31] ^ b[31]);
    e.p = p;
    e.lat = 33 + int'(s & a[31]) + int'(s & b[31]) + (neg ? ((p[31:0] == 32'd0) ? 2 : 3) : 0);
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom_range(1));
    while (!done && cyc < 80) begin
      if (busy) bc++;
      if (inj && cyc == 10) begin start = 1'b1; op_a = 32'h0000_1234; op_b = 32'h0000_5678; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (busy) bc++;
    e = sb.pop_front();
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("busy_cycles", 64'(bc), 64'(e.lat));
    chk("product", {hi, lo}, e.p);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("idle_alu", {29'd0, alu_op, alu_first}, {29'd0, 3'b010, 32'd0});
    if (inj) begin
      repeat (40) begin @(negedge clk); if (done) extra++; end
      chk("no_extra_done", 64'(extra), 64'(0));
      chk("product_held", {hi, lo}, e.p);
    end
  endtask
  initial begin
    int extra = 0;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_alu", {alu_second, alu_first}, 64'd0);
    chk("reset_alu_op", 64'(alu_op), 64'(3'b010));
    rst = 1'b0;
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
    run(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run(1'b1, 32'd1234, 32'd5678, 1'b0);
    run(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run(1'b0, 32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b1);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'h1234_5678; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("busy_in_iter", 64'(busy), 64'(1));
    chk("old_product_held", {hi, lo}, {32'd0, 32'hDEAD_BEEF} * {32'd0, 32'hCAFE_BABE});
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin @(negedge clk); if (done) extra++; end
    chk("no_done_after_abort", 64'(extra), 64'(0));
    run(1'b0, 32'd7, 32'd6, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
